// File: rtl/ft245_sync_device_pkg.sv
// Shared definitions for the FT245 synchronous-FIFO device model.
// Holds the RX state encodings, the error-flag bit layout and the idle bus value.
package ft245_sync_device_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_ARMED = 2'd1,
    RX_BURST = 2'd2
  } rx_state_t;

  localparam int ERR_RD_UNDERRUN   = 0;
  localparam int ERR_WR_OVERFLOW   = 1;
  localparam int ERR_RD_NO_OE      = 2;
  localparam int ERR_OE_WR_CONTEND = 3;

  // Packed so that member bit positions line up with the ERR_* indices above.
  typedef struct packed {
    logic oe_wr_contend;
    logic rd_no_oe;
    logic wr_overflow;
    logic rd_underrun;
  } err_t;

  localparam logic [7:0] BUS_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/ft245_sync_device_byte_fifo_sync.sv
// Single-clock byte FIFO with first-word-fall-through head, plus a look-ahead of the head and count after this edge.
// Zero-latency read of the head; pushes when full and pops when empty are silently ignored.
module byte_fifo_sync #(
  parameter int         ADDR_WIDTH = 4,
  parameter logic [7:0] EMPTY_VAL  = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic [7:0]            head_nxt,
  output logic [ADDR_WIDTH:0]   count_nxt,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [7:0]            mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  do_push, do_pop;

  always_comb begin
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    do_push  = wr_en & ~full;
    do_pop   = rd_en & ~empty;
    rd_data  = empty ? EMPTY_VAL : mem_q[rd_ptr_q];
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    count_nxt = count_q;
    if (do_push && !do_pop) begin
      count_nxt = count_q + CNT_ONE;
    end else if (!do_push && do_pop) begin
      count_nxt = count_q - CNT_ONE;
    end

    // A byte written this edge becomes the head when nothing older survives the pop.
    head_nxt = EMPTY_VAL;
    if (count_nxt != '0) begin
      if (empty || (count_q == CNT_ONE && do_pop)) begin
        head_nxt = wr_data;
      end else begin
        head_nxt = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/ft245_sync_device.sv
// Device side of an FT245 synchronous FIFO bridge: host byte FIFOs on one side, FT245 strobes on the other.
// Read data is registered one edge after oe_n/rd_n; rde_n/txe_n are registered flow control, misuse sets sticky flags.
module ft245_sync_device
  import ft245_sync_device_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_rx_wr,
  input  logic [7:0]  host_rx_data,
  output logic        host_rx_full,
  input  logic        host_tx_rd,
  output logic [7:0]  host_tx_data,
  output logic        host_tx_empty,
  input  logic [7:0]  ftdi_data_in,
  output logic [7:0]  ftdi_data_out,
  output logic        ftdi_data_oe,
  output logic        ftdi_rde_n,
  output logic        ftdi_txe_n,
  output logic        ftdi_suspend_n,
  input  logic        ftdi_rd_n,
  input  logic        ftdi_wr_n,
  input  logic        ftdi_oe_n,
  input  logic        ftdi_siwu,
  output logic [3:0]  err_flags,
  output logic [15:0] rx_byte_count,
  output logic [15:0] tx_byte_count
);

  localparam int                  DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  rx_state_t   rx_state_q, rx_state_d;
  logic        rde_n_q, rde_n_d;
  logic        txe_n_q, txe_n_d;
  logic [7:0]  data_out_q, data_out_d;
  err_t        err_q, err_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;

  logic oe, rd, wr;
  logic rx_pop, tx_push;

  logic [7:0]            rx_head_nxt;
  logic [ADDR_WIDTH:0]   rx_count_nxt, tx_count_nxt;
  logic                  rx_full, tx_empty;
  logic [7:0]            unused_rx_rd_data, unused_tx_head_nxt;
  logic                  unused_rx_empty, unused_tx_full;
  logic                  unused_siwu;

  assign unused_siwu = ftdi_siwu;

  byte_fifo_sync #(.ADDR_WIDTH(ADDR_WIDTH), .EMPTY_VAL(BUS_IDLE_BYTE)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (host_rx_wr),
    .wr_data   (host_rx_data),
    .rd_en     (rx_pop),
    .rd_data   (unused_rx_rd_data),
    .head_nxt  (rx_head_nxt),
    .count_nxt (rx_count_nxt),
    .full      (rx_full),
    .empty     (unused_rx_empty)
  );

  byte_fifo_sync #(.ADDR_WIDTH(ADDR_WIDTH), .EMPTY_VAL(BUS_IDLE_BYTE)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (tx_push),
    .wr_data   (ftdi_data_in),
    .rd_en     (host_tx_rd),
    .rd_data   (host_tx_data),
    .head_nxt  (unused_tx_head_nxt),
    .count_nxt (tx_count_nxt),
    .full      (unused_tx_full),
    .empty     (tx_empty)
  );

  always_comb begin
    oe = ~ftdi_oe_n;
    rd = ~ftdi_rd_n;
    wr = ~ftdi_wr_n;
    // A read strobe only counts once oe_n has been low for a full cycle.
    rx_pop  = oe & rd & ~rde_n_q & (rx_state_q != RX_IDLE);
    tx_push = wr & ~txe_n_q;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      RX_IDLE:  if (oe) rx_state_d = RX_ARMED;
      RX_ARMED: if (rd) rx_state_d = RX_BURST;
      RX_BURST: rx_state_d = RX_BURST;
      default:  rx_state_d = RX_IDLE;
    endcase
    if (!oe) begin
      rx_state_d = RX_IDLE;
    end
  end

  always_comb begin
    err_d = err_q;
    if (rd && oe && rde_n_q)            err_d.rd_underrun   = 1'b1;
    if (wr && txe_n_q)                  err_d.wr_overflow   = 1'b1;
    if (rd && rx_state_q == RX_IDLE)    err_d.rd_no_oe      = 1'b1;
    if (wr && oe)                       err_d.oe_wr_contend = 1'b1;

    rde_n_d    = (rx_count_nxt == '0);
    txe_n_d    = (tx_count_nxt == FULL_CNT);
    data_out_d = oe ? rx_head_nxt : data_out_q;
    rx_cnt_d   = rx_cnt_q + 16'(rx_pop);
    tx_cnt_d   = tx_cnt_q + 16'(tx_push);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rde_n_q    <= 1'b1;
      txe_n_q    <= 1'b0;
      data_out_q <= BUS_IDLE_BYTE;
      err_q      <= '0;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rde_n_q    <= rde_n_d;
      txe_n_q    <= txe_n_d;
      data_out_q <= data_out_d;
      err_q      <= err_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  assign host_rx_full   = rx_full;
  assign host_tx_empty  = tx_empty;
  assign ftdi_data_out  = data_out_q;
  assign ftdi_data_oe   = ~ftdi_oe_n;
  assign ftdi_rde_n     = rde_n_q;
  assign ftdi_txe_n     = txe_n_q;
  assign ftdi_suspend_n = 1'b1;
  assign err_flags      = err_q;
  assign rx_byte_count  = rx_cnt_q;
  assign tx_byte_count  = tx_cnt_q;

endmodule

// File: tb/tb_ft245_sync_device.sv
// Scoreboard bench: stimulus queues expected RX/TX bytes, a negedge monitor compares them when the DUT transfers.
// Directed flag/counter/reset checks run inline and share the same counters.
`timescale 1ns/1ps
module tb_ft245_sync_device;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_rx_wr;
  logic [7:0]  host_rx_data;
  logic        host_rx_full;
  logic        host_tx_rd;
  logic [7:0]  host_tx_data;
  logic        host_tx_empty;
  logic [7:0]  ftdi_data_in;
  logic [7:0]  ftdi_data_out;
  logic        ftdi_data_oe;
  logic        ftdi_rde_n;
  logic        ftdi_txe_n;
  logic        ftdi_suspend_n;
  logic        ftdi_rd_n;
  logic        ftdi_wr_n;
  logic        ftdi_oe_n;
  logic        ftdi_siwu;
  logic [3:0]  err_flags;
  logic [15:0] rx_byte_count;
  logic [15:0] tx_byte_count;

  always #8 clk = ~clk;

  ft245_sync_device #(.ADDR_WIDTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .host_rx_wr     (host_rx_wr),
    .host_rx_data   (host_rx_data),
    .host_rx_full   (host_rx_full),
    .host_tx_rd     (host_tx_rd),
    .host_tx_data   (host_tx_data),
    .host_tx_empty  (host_tx_empty),
    .ftdi_data_in   (ftdi_data_in),
    .ftdi_data_out  (ftdi_data_out),
    .ftdi_data_oe   (ftdi_data_oe),
    .ftdi_rde_n     (ftdi_rde_n),
    .ftdi_txe_n     (ftdi_txe_n),
    .ftdi_suspend_n (ftdi_suspend_n),
    .ftdi_rd_n      (ftdi_rd_n),
    .ftdi_wr_n      (ftdi_wr_n),
    .ftdi_oe_n      (ftdi_oe_n),
    .ftdi_siwu      (ftdi_siwu),
    .err_flags      (err_flags),
    .rx_byte_count  (rx_byte_count),
    .tx_byte_count  (tx_byte_count)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];
  logic oe_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // The FPGA captures the bus on the edge it pops, which needs oe_n low on the previous edge too.
  always @(negedge clk) begin
    if (rst_n && !ftdi_oe_n && !ftdi_rd_n && !ftdi_rde_n && oe_seen) begin
      if (rx_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected_pop: got %0h, expected no transfer", ftdi_data_out);
      end else begin
        check("rx_data", ftdi_data_out, rx_exp.pop_front());
      end
    end
    if (rst_n && host_tx_rd && !host_tx_empty) begin
      if (tx_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected_pop: got %0h, expected no transfer", host_tx_data);
      end else begin
        check("tx_data", host_tx_data, tx_exp.pop_front());
      end
    end
    oe_seen = rst_n && !ftdi_oe_n;
  end

  task automatic idle_inputs();
    host_rx_wr   = 1'b0;
    host_rx_data = 8'h00;
    host_tx_rd   = 1'b0;
    ftdi_data_in = 8'h00;
    ftdi_rd_n    = 1'b1;
    ftdi_wr_n    = 1'b1;
    ftdi_oe_n    = 1'b1;
    ftdi_siwu    = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    rx_exp.delete();
    tx_exp.delete();
    step(1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rde_n"},         ftdi_rde_n,     1);
    check({tag, "_txe_n"},         ftdi_txe_n,     0);
    check({tag, "_data_out"},      ftdi_data_out,  8'hFF);
    check({tag, "_err_flags"},     err_flags,      4'b0000);
    check({tag, "_rx_count"},      rx_byte_count,  0);
    check({tag, "_tx_count"},      tx_byte_count,  0);
    check({tag, "_host_rx_full"},  host_rx_full,   0);
    check({tag, "_host_tx_empty"}, host_tx_empty,  1);
    check({tag, "_suspend_n"},     ftdi_suspend_n, 1);
  endtask

  task automatic host_push(input logic [7:0] b, input bit expect_pop);
    host_rx_wr   = 1'b1;
    host_rx_data = b;
    if (expect_pop) rx_exp.push_back(b);
    step(1);
    host_rx_wr = 1'b0;
  endtask

  task automatic fpga_write(input logic [7:0] b, input bit accepted);
    ftdi_wr_n    = 1'b0;
    ftdi_data_in = b;
    if (accepted) tx_exp.push_back(b);
    step(1);
    ftdi_wr_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    step(2);
    check_reset("reset");
    rst_n = 1'b1;
    step(1);

    // Four-byte burst read
    host_push(8'h11, 1);
    host_push(8'h22, 1);
    host_push(8'h33, 1);
    host_push(8'h44, 1);
    check("burst_rde_low", ftdi_rde_n, 0);
    ftdi_oe_n = 1'b0;
    step(1);
    check("burst_data_oe", ftdi_data_oe, 1);
    ftdi_rd_n = 1'b0;
    step(3);
    check("burst_rde_before_last", ftdi_rde_n, 0);
    step(1);
    check("burst_rde_after_last", ftdi_rde_n, 1);
    check("burst_rx_count", rx_byte_count, 4);
    check("burst_err", err_flags, 4'b0000);
    ftdi_rd_n = 1'b1;
    ftdi_oe_n = 1'b1;
    step(1);

    // TX fill to depth, overflow, host drain
    do_reset();
    for (int i = 0; i < 16; i++) begin
      fpga_write(8'hA0 + 8'(i), 1);
      if (i == 14) check("tx_txe_before_full", ftdi_txe_n, 0);
    end
    check("tx_txe_full", ftdi_txe_n, 1);
    fpga_write(8'hEE, 0);
    check("tx_overflow_err", err_flags, 4'b0010);
    check("tx_count", tx_byte_count, 16);
    check("tx_not_empty", host_tx_empty, 0);
    host_tx_rd = 1'b1;
    step(16);
    host_tx_rd = 1'b0;
    check("tx_drained_empty", host_tx_empty, 1);
    check("tx_drained_txe", ftdi_txe_n, 0);

    // Read strobe without output enable
    do_reset();
    host_push(8'h3C, 0);
    ftdi_rd_n = 1'b0;
    step(1);
    ftdi_rd_n = 1'b1;
    check("rd_no_oe_err", err_flags, 4'b0100);
    check("rd_no_oe_count", rx_byte_count, 0);
    check("rd_no_oe_rde", ftdi_rde_n, 0);

    // Underrun after single byte
    do_reset();
    host_push(8'h5A, 1);
    ftdi_oe_n = 1'b0;
    step(1);
    ftdi_rd_n = 1'b0;
    step(3);
    check("underrun_count", rx_byte_count, 1);
    check("underrun_err", err_flags, 4'b0001);
    check("underrun_data", ftdi_data_out, 8'hFF);
    check("underrun_rde", ftdi_rde_n, 1);
    ftdi_rd_n = 1'b1;
    ftdi_oe_n = 1'b1;
    step(1);

    // Reset in the middle of a burst
    do_reset();
    host_push(8'hA1, 1);
    host_push(8'hA2, 1);
    host_push(8'hA3, 1);
    host_push(8'hA4, 1);
    ftdi_oe_n = 1'b0;
    step(1);
    ftdi_rd_n = 1'b0;
    step(2);
    check("midburst_count", rx_byte_count, 2);
    rst_n = 1'b0;
    step(1);
    check_reset("midburst_reset");
    rst_n     = 1'b1;
    ftdi_rd_n = 1'b1;
    ftdi_oe_n = 1'b1;
    rx_exp.delete();
    step(1);
    check("post_reset_rde", ftdi_rde_n, 1);

    // Host push and FPGA pop on the same edge at count 1
    do_reset();
    host_push(8'h77, 1);
    ftdi_oe_n = 1'b0;
    step(1);
    ftdi_rd_n    = 1'b0;
    host_rx_wr   = 1'b1;
    host_rx_data = 8'h88;
    step(1);
    host_rx_wr = 1'b0;
    ftdi_rd_n  = 1'b1;
    ftdi_oe_n  = 1'b1;
    check("swap_rde", ftdi_rde_n, 0);
    check("swap_data", ftdi_data_out, 8'h88);
    check("swap_count", rx_byte_count, 1);
    step(1);
    check("swap_rde_hold", ftdi_rde_n, 0);

    // RX full boundary
    do_reset();
    for (int i = 0; i < 15; i++) host_push(8'(i), 0);
    check("rx_not_full_15", host_rx_full, 0);
    host_push(8'hF0, 0);
    check("rx_full_16", host_rx_full, 1);
    host_push(8'hF1, 0);
    check("rx_full_17", host_rx_full, 1);

    // Write during output enable: flagged, push still happens
    do_reset();
    ftdi_oe_n = 1'b0;
    fpga_write(8'hC3, 0);
    ftdi_oe_n = 1'b1;
    check("contend_err", err_flags, 4'b1000);
    check("contend_tx_count", tx_byte_count, 1);
    check("contend_tx_data", host_tx_data, 8'hC3);
    step(1);

    check("rx_queue_drained", rx_exp.size(), 0);
    check("tx_queue_drained", tx_exp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
